// File: rtl/loss_error.sv
// loss_error
//   Error-generation stage of the perceptron training loop. Pairs one result
//   sample (res_*) with one target sample (tgt_*). The stage then returns
//   ((tgt - res) <<< SHIFT) on the err_* stream. The result is saturated to
//   16-bit two's complement.
//
// Parameters
//   SHIFT     arithmetic left shift applied to the error, 0..8
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous reset, active-low
//   en        global enable; 0 freezes all state and outputs
//   res_stb   result valid          res_dat  result value (unsigned 8)
//   res_rdy   result slot empty and accepting
//   tgt_stb   target valid          tgt_dat  target value (unsigned 8)
//   tgt_rdy   target slot empty and accepting
//   err_stb   error valid           err_dat  error (signed 16)
//   err_rdy   downstream accepts error
//   stat_clr  clear statistics counters
//   stat_smp  samples completed (wrapping)
//   stat_mis  samples with nonzero error (saturating)
//
// Configuration
//   LOSS_ERROR_STATS_EN  defined: statistics counters present.
//                        undefined: stat_* tied to 0 and stat_clr ignored.

module loss_error #(
    parameter int SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        res_stb,
    input  logic [7:0]  res_dat,
    output logic        res_rdy,
    input  logic        tgt_stb,
    input  logic [7:0]  tgt_dat,
    output logic        tgt_rdy,
    output logic        err_stb,
    output logic [15:0] err_dat,
    input  logic        err_rdy,
    input  logic        stat_clr,
    output logic [15:0] stat_smp,
    output logic [15:0] stat_mis
);

    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    logic [1:0]         state;
    logic               res_full;
    logic               tgt_full;
    logic [7:0]         res_q;
    logic [7:0]         tgt_q;
    logic               res_take;
    logic               tgt_take;
    logic               err_take;
    logic signed [8:0]  diff;
    logic [16:0]        wide;
    logic [15:0]        sat;

    // rst is folded in so both ready outputs are low during the reset cycle itself
    assign res_rdy  = rst & en & (state == FILL) & ~res_full;
    assign tgt_rdy  = rst & en & (state == FILL) & ~tgt_full;
    assign res_take = res_stb & res_rdy;
    assign tgt_take = tgt_stb & tgt_rdy;
    assign err_take = en & err_stb & err_rdy & (state == SEND);

    // 9-bit signed difference, sign-extended to 17 bits before shifting so
    // that the full shifted range (+/-65280) is representable before saturation
    always_comb begin
        diff = $signed({1'b0, tgt_q}) - $signed({1'b0, res_q});
        wide = {{8{diff[8]}}, diff} << SHIFT;
        if (wide[16] != wide[15]) begin
            sat = wide[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            sat = wide[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= FILL;
            res_full <= 1'b0;
            tgt_full <= 1'b0;
            res_q    <= '0;
            tgt_q    <= '0;
            err_stb  <= 1'b0;
            err_dat  <= '0;
        end else if (en) begin
            if (res_take) begin
                res_q    <= res_dat;
                res_full <= 1'b1;
            end
            if (tgt_take) begin
                tgt_q    <= tgt_dat;
                tgt_full <= 1'b1;
            end
            case (state)
                FILL: if (res_full && tgt_full) state <= CALC;
                CALC: begin
                    err_dat <= sat;
                    err_stb <= 1'b1;
                    state   <= SEND;
                end
                SEND: if (err_take) begin
                    err_stb  <= 1'b0;
                    res_full <= 1'b0;
                    tgt_full <= 1'b0;
                    state    <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef LOSS_ERROR_STATS_EN
    logic [15:0] smp_q;
    logic [15:0] mis_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            smp_q <= '0;
            mis_q <= '0;
        end else if (en) begin
            if (stat_clr) begin
                smp_q <= '0;
                mis_q <= '0;
            end else if (err_take) begin
                smp_q <= smp_q + 16'd1;
                if (err_dat != 16'd0 && mis_q != 16'hFFFF) begin
                    mis_q <= mis_q + 16'd1;
                end
            end
        end
    end

    assign stat_smp = smp_q;
    assign stat_mis = mis_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_smp = '0;
    assign stat_mis = '0;
`endif

endmodule

// File: tb/tb_loss_error.sv
module tb_loss_error;

    logic        clk = 1'b0;
    logic        rst, en, res_stb, tgt_stb, err_rdy, stat_clr;
    logic [7:0]  res_dat, tgt_dat;
    logic        res_rdy0, tgt_rdy0, err_stb0, res_rdy8, tgt_rdy8, err_stb8;
    logic [15:0] err_dat0, stat_smp0, stat_mis0, err_dat8, stat_smp8, stat_mis8;

    int checks = 0;
    int errors = 0;
    int smp_m  = 0;
    int mis_m  = 0;
    logic [15:0] q0[$];
    logic [15:0] q8[$];

    always #5 clk = ~clk;

    loss_error #(.SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .en(en),
        .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy0),
        .tgt_stb(tgt_stb), .tgt_dat(tgt_dat), .tgt_rdy(tgt_rdy0),
        .err_stb(err_stb0), .err_dat(err_dat0), .err_rdy(err_rdy),
        .stat_clr(stat_clr), .stat_smp(stat_smp0), .stat_mis(stat_mis0)
    );

    loss_error #(.SHIFT(8)) dut8 (
        .clk(clk), .rst(rst), .en(en),
        .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy8),
        .tgt_stb(tgt_stb), .tgt_dat(tgt_dat), .tgt_rdy(tgt_rdy8),
        .err_stb(err_stb8), .err_dat(err_dat8), .err_rdy(err_rdy),
        .stat_clr(stat_clr), .stat_smp(stat_smp8), .stat_mis(stat_mis8)
    );

    function automatic logic [15:0] model(input logic [7:0] r, input logic [7:0] t, input int sh);
        int v;
        v = (int'(t) - int'(r)) * (1 << sh);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic [15:0] exp_smp();
`ifdef LOSS_ERROR_STATS_EN
        return smp_m[15:0];
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [15:0] exp_mis();
`ifdef LOSS_ERROR_STATS_EN
        return mis_m[15:0];
`else
        return 16'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] t);
        q0.push_back(model(r, t, 0));
        q8.push_back(model(r, t, 8));
    endtask

    task automatic pop_exp(output logic [15:0] e0, output logic [15:0] e8);
        e0 = 16'hxxxx;
        e8 = 16'hxxxx;
        if (q0.size() > 0) e0 = q0.pop_front();
        if (q8.size() > 0) e8 = q8.pop_front();
    endtask

    // Bounded wait for the error strobe; the caller judges the outcome.
    task automatic await_err(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (err_stb0 === 1'b1) begin
                got = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic count_sample(input logic [15:0] e0);
        smp_m = (smp_m + 1) % 65536;
        if (e0 != 16'd0 && mis_m < 65535) mis_m++;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; res_stb = 1'b0; tgt_stb = 1'b0; err_rdy = 1'b0;
        stat_clr = 1'b0; res_dat = '0; tgt_dat = '0;
        tick(); tick();
        checks++;
        if (res_rdy0 !== 1'b0 || tgt_rdy0 !== 1'b0)
            begin errors++; $display("FAIL reset_rdy_low got=%b%b exp=00", res_rdy0, tgt_rdy0); end
        rst = 1'b1;
        #1;
        smp_m = 0; mis_m = 0;
        checks++;
        if ({res_rdy0, tgt_rdy0, res_rdy8, tgt_rdy8} !== 4'b1111)
            begin errors++; $display("FAIL reset_rdy_high got=%b%b exp=11", res_rdy0, tgt_rdy0); end
        checks++;
        if (err_stb0 !== 1'b0 || err_dat0 !== 16'h0 || err_stb8 !== 1'b0)
            begin errors++; $display("FAIL reset_err got=%b/%h exp=0/0000", err_stb0, err_dat0); end
        checks++;
        if (stat_smp0 !== 16'h0 || stat_mis0 !== 16'h0)
            begin errors++; $display("FAIL reset_stats got=%h/%h exp=0000/0000", stat_smp0, stat_mis0); end
    endtask

    task automatic test_basic();
        logic [15:0] e0, e8;
        err_rdy = 1'b1; res_dat = 8'h00; tgt_dat = 8'hFF; res_stb = 1'b1; tgt_stb = 1'b1;
        push(8'h00, 8'hFF);
        tick();
        res_stb = 1'b0; tgt_stb = 1'b0;
        checks++;
        if (res_rdy0 !== 1'b0 || tgt_rdy0 !== 1'b0)
            begin errors++; $display("FAIL basic_slots_full got=%b%b exp=00", res_rdy0, tgt_rdy0); end
        tick();
        checks++;
        if (err_stb0 !== 1'b0)
            begin errors++; $display("FAIL basic_calc_stb got=%b exp=0", err_stb0); end
        tick();
        checks++;
        if (err_stb0 !== 1'b1 || err_stb8 !== 1'b1)
            begin errors++; $display("FAIL basic_latency got=%b%b exp=11", err_stb0, err_stb8); end
        pop_exp(e0, e8);
        checks++;
        if (err_dat0 !== e0 || err_dat8 !== e8)
            begin errors++; $display("FAIL basic_err got=%h/%h exp=%h/%h", err_dat0, err_dat8, e0, e8); end
        tick();
        count_sample(e0);
        checks++;
        if (err_stb0 !== 1'b0 || res_rdy0 !== 1'b1 || tgt_rdy0 !== 1'b1)
            begin errors++; $display("FAIL basic_release got=%b%b%b exp=011", err_stb0, res_rdy0, tgt_rdy0); end
        checks++;
        if (stat_smp0 !== exp_smp() || stat_mis0 !== exp_mis())
            begin errors++; $display("FAIL basic_stats got=%h/%h exp=%h/%h", stat_smp0, stat_mis0, exp_smp(), exp_mis()); end
    endtask

    task automatic test_order();
        logic [15:0] e0, e8;
        bit got;
        err_rdy = 1'b1; res_dat = 8'hFF; res_stb = 1'b1; tgt_stb = 1'b0;
        tick();
        res_dat = 8'h11;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) begin
                tgt_stb = 1'b1; tgt_dat = 8'h00;
                push(8'hFF, 8'h00);
            end
            checks++;
            if (res_rdy0 !== 1'b0 || tgt_rdy0 !== 1'b1)
                begin errors++; $display("FAIL order_rdy_c%0d got=%b%b exp=01", i, res_rdy0, tgt_rdy0); end
            if (i < 4) tick();
        end
        tick();
        res_stb = 1'b0; tgt_stb = 1'b0;
        await_err(got);
        checks++;
        if (!got) begin errors++; $display("FAIL order_timeout got=0 exp=1"); end
        pop_exp(e0, e8);
        checks++;
        if (err_dat0 !== e0 || err_dat8 !== e8)
            begin errors++; $display("FAIL order_err got=%h/%h exp=%h/%h", err_dat0, err_dat8, e0, e8); end
        tick();
        count_sample(e0);
        checks++;
        if (stat_smp0 !== exp_smp() || stat_mis0 !== exp_mis())
            begin errors++; $display("FAIL order_stats got=%h/%h exp=%h/%h", stat_smp0, stat_mis0, exp_smp(), exp_mis()); end
    endtask

    task automatic test_saturation();
        logic [7:0] rv [6] = '{8'h40, 8'h41, 8'h00, 8'h00, 8'h80, 8'h81};
        logic [7:0] tv [6] = '{8'h41, 8'h40, 8'h80, 8'h7F, 8'h00, 8'h00};
        logic [15:0] e0, e8;
        bit got;
        err_rdy = 1'b1;
        foreach (rv[k]) begin
            res_dat = rv[k]; tgt_dat = tv[k]; res_stb = 1'b1; tgt_stb = 1'b1;
            push(rv[k], tv[k]);
            tick();
            res_stb = 1'b0; tgt_stb = 1'b0;
            await_err(got);
            pop_exp(e0, e8);
            checks++;
            if (!got || err_dat0 !== e0 || err_dat8 !== e8)
                begin errors++; $display("FAIL sat_%0d got=%h/%h exp=%h/%h", k, err_dat0, err_dat8, e0, e8); end
            tick();
            count_sample(e0);
        end
        checks++;
        if (stat_smp0 !== exp_smp() || stat_mis0 !== exp_mis())
            begin errors++; $display("FAIL sat_stats got=%h/%h exp=%h/%h", stat_smp0, stat_mis0, exp_smp(), exp_mis()); end
    endtask

    task automatic test_stall();
        logic [15:0] e0, e8;
        bit got;
        err_rdy = 1'b0; res_dat = 8'h10; tgt_dat = 8'h30; res_stb = 1'b1; tgt_stb = 1'b1;
        push(8'h10, 8'h30);
        tick();
        res_stb = 1'b0; tgt_stb = 1'b0;
        await_err(got);
        pop_exp(e0, e8);
        checks++;
        if (!got || err_dat0 !== e0 || err_dat8 !== e8)
            begin errors++; $display("FAIL stall_err got=%h/%h exp=%h/%h", err_dat0, err_dat8, e0, e8); end
        for (int i = 0; i < 5; i++) begin
            en = i[0]; res_stb = 1'b1; tgt_stb = 1'b1; res_dat = 8'(i); tgt_dat = 8'hEE;
            tick();
            checks++;
            if (err_stb0 !== 1'b1 || err_dat0 !== e0 || err_dat8 !== e8 || res_rdy0 !== 1'b0)
                begin errors++; $display("FAIL stall_hold_%0d got=%b/%h exp=1/%h", i, err_stb0, err_dat0, e0); end
        end
        en = 1'b0; err_rdy = 1'b1; res_stb = 1'b0; tgt_stb = 1'b0;
        tick();
        checks++;
        if (err_stb0 !== 1'b1)
            begin errors++; $display("FAIL stall_en_off_accept got=%b exp=1", err_stb0); end
        en = 1'b1;
        tick();
        count_sample(e0);
        checks++;
        if (err_stb0 !== 1'b0 || res_rdy0 !== 1'b1 || tgt_rdy0 !== 1'b1)
            begin errors++; $display("FAIL stall_release got=%b%b%b exp=011", err_stb0, res_rdy0, tgt_rdy0); end
        checks++;
        if (stat_smp0 !== exp_smp() || stat_mis0 !== exp_mis())
            begin errors++; $display("FAIL stall_stats got=%h/%h exp=%h/%h", stat_smp0, stat_mis0, exp_smp(), exp_mis()); end
    endtask

    task automatic test_clear();
        logic [15:0] e0, e8;
        bit got;
        err_rdy = 1'b1; res_dat = 8'h80; tgt_dat = 8'h80; res_stb = 1'b1; tgt_stb = 1'b1;
        push(8'h80, 8'h80);
        tick();
        res_stb = 1'b0; tgt_stb = 1'b0;
        await_err(got);
        pop_exp(e0, e8);
        checks++;
        if (!got || err_dat0 !== e0 || err_dat8 !== e8)
            begin errors++; $display("FAIL clear_err got=%h/%h exp=%h/%h", err_dat0, err_dat8, e0, e8); end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        smp_m = 0; mis_m = 0;
        checks++;
        if (err_stb0 !== 1'b0 || stat_smp0 !== exp_smp() || stat_mis0 !== exp_mis())
            begin errors++; $display("FAIL clear_stats got=%h/%h exp=%h/%h", stat_smp0, stat_mis0, exp_smp(), exp_mis()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rv [3] = '{8'h05, 8'h33, 8'hC0};
        logic [7:0] tv [3] = '{8'h09, 8'h33, 8'h10};
        logic [15:0] e0, e8;
        err_rdy = 1'b1;
        foreach (rv[k]) begin
            res_dat = rv[k]; tgt_dat = tv[k]; res_stb = 1'b1; tgt_stb = 1'b1;
            push(rv[k], tv[k]);
            tick();
            res_stb = 1'b0; tgt_stb = 1'b0;
            tick(); tick();
            pop_exp(e0, e8);
            checks++;
            if (err_stb0 !== 1'b1 || err_dat0 !== e0 || err_dat8 !== e8)
                begin errors++; $display("FAIL b2b_%0d got=%b/%h/%h exp=1/%h/%h", k, err_stb0, err_dat0, err_dat8, e0, e8); end
            tick();
            count_sample(e0);
            checks++;
            if (res_rdy0 !== 1'b1 || tgt_rdy0 !== 1'b1 || err_stb0 !== 1'b0)
                begin errors++; $display("FAIL b2b_rdy_%0d got=%b%b%b exp=110", k, res_rdy0, tgt_rdy0, err_stb0); end
        end
        checks++;
        if (stat_smp0 !== exp_smp() || stat_mis0 !== exp_mis())
            begin errors++; $display("FAIL b2b_stats got=%h/%h exp=%h/%h", stat_smp0, stat_mis0, exp_smp(), exp_mis()); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] e0, e8;
        bit got;
        err_rdy = 1'b0; res_dat = 8'h01; tgt_dat = 8'h02; res_stb = 1'b1; tgt_stb = 1'b1;
        tick();
        res_stb = 1'b0; tgt_stb = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if (err_stb0 !== 1'b0 || err_dat0 !== 16'h0)
            begin errors++; $display("FAIL midrst_err got=%b/%h exp=0/0000", err_stb0, err_dat0); end
        rst = 1'b1; err_rdy = 1'b1;
        #1;
        smp_m = 0; mis_m = 0;
        checks++;
        if (res_rdy0 !== 1'b1 || tgt_rdy0 !== 1'b1 || stat_smp0 !== exp_smp())
            begin errors++; $display("FAIL midrst_state got=%b%b/%h exp=11/%h", res_rdy0, tgt_rdy0, stat_smp0, exp_smp()); end
        res_dat = 8'h07; tgt_dat = 8'h05; res_stb = 1'b1; tgt_stb = 1'b1;
        push(8'h07, 8'h05);
        tick();
        res_stb = 1'b0; tgt_stb = 1'b0;
        await_err(got);
        pop_exp(e0, e8);
        checks++;
        if (!got || err_dat0 !== e0 || err_dat8 !== e8)
            begin errors++; $display("FAIL midrst_next got=%h/%h exp=%h/%h", err_dat0, err_dat8, e0, e8); end
        tick();
        count_sample(e0);
        checks++;
        if (stat_smp0 !== exp_smp() || stat_mis0 !== exp_mis())
            begin errors++; $display("FAIL midrst_stats got=%h/%h exp=%h/%h", stat_smp0, stat_mis0, exp_smp(), exp_mis()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_saturation();
        test_stall();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
